// File: rtl/im_pipe.sv
// im_pipe: single-port word memory with per-byte write enables and a
// one-entry registered read response behind a valid/ready handshake.
// Read latency is exactly one cycle. A held response stalls new requests.
// Optional feature macro: IM_PIPE_PARITY_EN
//   defined   -> one even-parity bit per stored byte, rsp_err flags a
//                mismatch on the returned word, debug input inj_par flips
//                the parity written with the enabled bytes.
//   undefined -> no parity storage, rsp_err held at 0, no inj_par port.
// Memory contents are never reset.
module im_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
`ifdef IM_PIPE_PARITY_EN
    input  logic                  inj_par,
`endif
    output logic                  rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

`ifdef IM_PIPE_PARITY_EN
    // Even parity of every byte of a word: bit i is the XOR of byte i.
    function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        p = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction
`endif

    // Storage (not reset).
    logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef IM_PIPE_PARITY_EN
    logic [NB-1:0]     par_q [DEPTH];
    logic [NB-1:0]     rd_par_s;
    logic [NB-1:0]     wr_par_s;
`endif

    // Response register.
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    // Request decode and write merge.
    logic              accept_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic [DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] be_mask_s;
    logic [DATA_W-1:0] wr_word_s;

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Decode the handshake; reset suppresses both writes and new reads.
    always_comb begin
        accept_s  = req_valid && req_ready;
        wr_en_s   = accept_s && req_write && rst;
        rd_en_s   = accept_s && !req_write && rst;
        rd_word_s = mem_q[req_addr];
    end

    // Merge enabled bytes of the write data into the current word.
    always_comb begin
        be_mask_s = {DATA_W{1'b0}};
        for (int i = 0; i < NB; i++) begin
            be_mask_s[8*i +: 8] = {8{req_be[i]}};
        end
        wr_word_s = (rd_word_s & ~be_mask_s) | (req_wdata & be_mask_s);
    end

`ifdef IM_PIPE_PARITY_EN
    // Parity for the merged word: enabled bytes get fresh (optionally
    // inverted) parity, untouched bytes keep their stored bit.
    always_comb begin
        rd_par_s = par_q[req_addr];
        wr_par_s = rd_par_s;
        for (int i = 0; i < NB; i++) begin
            if (req_be[i]) begin
                wr_par_s[i] = (^req_wdata[8*i +: 8]) ^ inj_par;
            end else begin
                wr_par_s[i] = rd_par_s[i];
            end
        end
    end

    // Parity storage follows the data write.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            par_q[req_addr] <= wr_par_s;
        end
    end
`endif

    // Word storage; a zero byte-enable write rewrites the same value.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[req_addr] <= wr_word_s;
        end
    end

    // Next response: load on accepted read, retire when consumed, else hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (rd_en_s) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_word_s;
`ifdef IM_PIPE_PARITY_EN
            rsp_err_d   = |(byte_parity(rd_word_s) ^ rd_par_s);
`else
            rsp_err_d   = 1'b0;
`endif
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Response register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_im_pipe.sv
// tb_im_pipe: directed scenarios plus randomized traffic for im_pipe, checked
// against a word-level memory model and an expected-response queue.
// Build with +define+IM_PIPE_PARITY_EN to exercise the parity feature.
module tb_im_pipe;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int NB     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [NB-1:0]     req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              inj_par;

    always #5 clk = ~clk;

    im_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
`ifdef IM_PIPE_PARITY_EN
        .inj_par   (inj_par),
`endif
        .rsp_err   (rsp_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: memory words, bytes carrying injected parity, pending responses.
    logic [DATA_W-1:0] mem_m [int];
    logic [NB-1:0]     bad_m [int];
    logic [DATA_W-1:0] exp_data_q [$];
    logic              exp_err_q  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the inputs currently driven: check the handshake, update
    // the model at the edge, then check the response that follows it.
    task automatic step();
        logic exp_ready;
        int   a;
        @(negedge clk);
        exp_ready = (exp_data_q.size() == 0) || rsp_ready;
        check("req_ready", req_ready, exp_ready);
        if (!rst) begin
            exp_data_q.delete();
            exp_err_q.delete();
        end else begin
            if (exp_data_q.size() != 0 && rsp_ready) begin
                check("consumed_rdata", rsp_rdata, exp_data_q[0]);
                check("consumed_err", rsp_err, exp_err_q[0]);
                void'(exp_data_q.pop_front());
                void'(exp_err_q.pop_front());
            end
            if (req_valid && exp_ready) begin
                a = int'(req_addr);
                if (req_write) begin
                    if (!mem_m.exists(a)) begin
                        mem_m[a] = '0;
                        bad_m[a] = '0;
                    end
                    for (int i = 0; i < NB; i++) begin
                        if (req_be[i]) begin
                            mem_m[a][8*i +: 8] = req_wdata[8*i +: 8];
`ifdef IM_PIPE_PARITY_EN
                            bad_m[a][i] = inj_par;
`endif
                        end
                    end
                end else begin
                    exp_data_q.push_back(mem_m[a]);
                    exp_err_q.push_back(|bad_m[a]);
                end
            end
        end
        @(posedge clk);
        #1;
        check("rsp_valid", rsp_valid, exp_data_q.size() != 0);
        if (exp_data_q.size() != 0) begin
            check("rsp_rdata", rsp_rdata, exp_data_q[0]);
            check("rsp_err", rsp_err, exp_err_q[0]);
        end
    endtask

    task automatic do_write(input int a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = ADDR_W'(a);
        req_wdata = d;
        req_be    = be;
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_read(input int a);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = ADDR_W'(a);
        step();
        req_valid = 1'b0;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        step();
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        inj_par   = 1'b0;

        // Reset for two cycles.
        repeat (2) step();
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0000_0000);
        check("reset_req_ready", req_ready, 1'b1);
        rst       = 1'b1;
        rsp_ready = 1'b1;

        // Give every address used later a defined value.
        for (int a = 0; a < 16; a++) do_write(a, $urandom, 4'hF);

        // Full write then read of the same address in the next cycle.
        do_write(16, 32'hDEAD_BEEF, 4'hF);
        do_read(16);
        check("wr_rd_valid", rsp_valid, 1'b1);
        check("wr_rd_data", rsp_rdata, 32'hDEAD_BEEF);

        // Partial byte enables, then a zero byte-enable write.
        do_write(16, 32'h1122_3344, 4'b0101);
        do_read(16);
        check("be_merge", rsp_rdata, 32'hDE22_BE44);
        do_write(16, 32'hFFFF_FFFF, 4'b0000);
        do_read(16);
        check("be_zero", rsp_rdata, 32'hDE22_BE44);
        idle();

        // Backpressure: response held three cycles, next read waits.
        do_read(16);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'd3;
        repeat (3) begin
            step();
            check("bp_ready", req_ready, 1'b0);
            check("bp_hold", rsp_rdata, 32'hDE22_BE44);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 1'b1);
        step();
        check("bp_next_data", rsp_rdata, mem_m[3]);
        idle();

        // Streaming reads of 0..7 at full rate.
        for (int a = 0; a < 8; a++) begin
            do_read(a);
            check("stream_valid", rsp_valid, 1'b1);
            check("stream_data", rsp_rdata, mem_m[a]);
        end
        idle();

        // Reset in the middle of a stream.
        for (int a = 0; a < 4; a++) do_read(a);
        rst = 1'b0;
        do_read(4);
        check("midreset_valid", rsp_valid, 1'b0);
        rst = 1'b1;
        idle();

`ifdef IM_PIPE_PARITY_EN
        // Injected parity error, then a clean rewrite.
        do_write(20, 32'h0000_0000, 4'hF);
        inj_par = 1'b1;
        do_write(20, 32'h0000_00FF, 4'h1);
        inj_par = 1'b0;
        do_read(20);
        check("par_inj_err", rsp_err, 1'b1);
        do_write(20, 32'h0000_00FF, 4'h1);
        do_read(20);
        check("par_clean_err", rsp_err, 1'b0);
        idle();
`endif

        // Randomized traffic over the initialized addresses.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) != 0);
            req_valid = $urandom_range(0, 1);
            req_write = $urandom_range(0, 1);
            req_addr  = ADDR_W'($urandom_range(0, 16));
            req_wdata = $urandom;
            req_be    = NB'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef IM_PIPE_PARITY_EN
            inj_par   = ($urandom_range(0, 7) == 0);
`endif
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/im_pipe.md
IM_PIPE -- requirements
Module: im_pipe

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 32, word width in bits; multiple of 8.
- ADDR_W, 16, word-address width; depth = 2**ADDR_W words.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; bit i covers byte i
- rsp_valid  out  1  read data present
- rsp_ready  in  1  consumer takes read data
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  parity error on the returned word (see REQ-016)
REQ-003 The block SHALL use one clock and a synchronous active-low reset: clock named clk, reset named rst.

Function
REQ-004 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-005 req_ready SHALL equal !rsp_valid || rsp_ready (combinational).
REQ-006 Accepted write: each byte i with req_be[i]=1 SHALL be updated at that edge; other bytes unchanged; no response generated.
REQ-007 Write with req_be all zero SHALL be accepted and SHALL leave memory unchanged.
REQ-008 Accepted read: rsp_valid SHALL be 1 and rsp_rdata SHALL hold mem[req_addr] in the next cycle (latency exactly 1).
REQ-009 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-010 While rsp_valid && !rsp_ready, rsp_rdata and rsp_err SHALL hold stable and no new request SHALL be accepted.
REQ-011 If rsp_valid && rsp_ready with no new accepted read, rsp_valid SHALL go 0 next cycle.
REQ-012 If rsp_ready=1 every cycle, back-to-back reads SHALL complete at one per cycle.
REQ-013 Addresses SHALL map one-to-one onto the 2**ADDR_W words; no out-of-range case exists.
REQ-014 Memory contents SHALL NOT be reset. Contents are undefined until written.

Reset
REQ-015 While rst=0 at a rising edge, the block SHALL do the following:
- set rsp_valid=0, rsp_rdata=0 and rsp_err=0;
- drop any pending response;
- suppress all writes.
req_ready SHALL then read 1 through REQ-005.

Configuration
REQ-016 Macro IM_PIPE_PARITY_EN controls per-byte parity:
- Defined: store one even-parity bit per byte, written with its byte. rsp_err=1 when any returned byte's stored parity mismatches its data. Also add debug input inj_par (1 bit): when high during a write, it inverts the stored parity of the written bytes.
- Undefined: no parity storage; rsp_err tied 0; no inj_par port.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Reset: rst=0 for 2 cycles -> rsp_valid=0, rsp_err=0, req_ready=1.
- Write/read: write 0xDEADBEEF to addr 0x0010 with be=4'hF; read 0x0010 next cycle -> rsp_valid=1 one cycle later, rsp_rdata=0xDEADBEEF.
- Byte enables and zero be:
  - Write 0x11223344 with be=4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
  - Then write with be=0 -> read still returns 0xDE22BE44.
- Backpressure: read 0x0010 with rsp_ready=0 for 3 cycles -> rsp_rdata held, req_ready=0 throughout. A new request held on req_valid is accepted only in the cycle rsp_ready=1.
- Streaming: reads of addresses 0..7 with rsp_ready=1 -> eight consecutive rsp_valid cycles, data in order. Also assert rst=0 mid-stream -> rsp_valid=0 next cycle.
- With IM_PIPE_PARITY_EN: write 0x000000FF with inj_par=1, be=4'h1; read back -> rsp_err=1. Rewrite the same word without inj_par -> rsp_err=0.
